// File: rtl/lod_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : lod_norm_pipe
//  Purpose  : Three-stage leading-one detector and normaliser. Stage 1
//             converts the operand to sign/magnitude, stage 2 counts the
//             leading zeros of the magnitude with a halving tree, stage 3
//             shifts the magnitude left so its top bit is set.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             in_valid/in_ready    - input handshake
//             in_data, in_signed   - operand and signedness select
//             out_valid/out_ready  - output handshake
//             out_sign, out_cnt,
//             out_norm, out_zero   - sign, leading-zero count, normalised
//                                    magnitude, zero-magnitude flag
//  Revision : 1.0 - initial release
// ============================================================================
module lod_norm_pipe #(
    parameter  int N = 16,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [S-1:0] out_cnt,
    output logic [N-1:0] out_norm,
    output logic         out_zero
);

    // Stage 1: sign / magnitude
    logic         r_v1_q,    w_v1_d;
    logic         r_sign1_q, w_sign1_d;
    logic [N-1:0] r_mag1_q,  w_mag1_d;
    // Stage 2: leading-zero count
    logic         r_v2_q,    w_v2_d;
    logic         r_sign2_q, w_sign2_d;
    logic [N-1:0] r_mag2_q,  w_mag2_d;
    logic [S-1:0] r_cnt2_q,  w_cnt2_d;
    logic         r_zero2_q, w_zero2_d;
    // Stage 3: normalising shift
    logic         r_v3_q,    w_v3_d;
    logic         r_sign3_q, w_sign3_d;
    logic [S-1:0] r_cnt3_q,  w_cnt3_d;
    logic [N-1:0] r_norm3_q, w_norm3_d;
    logic         r_zero3_q, w_zero3_d;

    logic         w_en1, w_en2, w_en3;
    logic         w_in_sign;

    // Halving tree: level l inspects the upper half of the current window.
    // If that half is empty it sets count bit S-1-l and shifts the window up
    // by the half width, so each level resolves one bit of the count, MSB
    // first. The final level only needs the top bit, so no shift is built
    // after it.
    logic [N-1:0] w_lvl [0:S-1];
    logic [S-1:0] w_tree_cnt;
    logic         w_mag_zero;

    assign w_lvl[0]   = r_mag1_q;
    assign w_mag_zero = ~|r_mag1_q;

    for (genvar l = 0; l < S; l++) begin : g_lvl
        localparam int c_HALF = N >> (l + 1);
        assign w_tree_cnt[S-1-l] = ~|w_lvl[l][N-1 -: c_HALF];
        if (l < S - 1) begin : g_next
            assign w_lvl[l+1] = w_tree_cnt[S-1-l] ? (w_lvl[l] << c_HALF) : w_lvl[l];
        end
    end

    // Enables ripple back from the output; a stage may load when it is empty
    // or when its successor is about to take its current contents.
    assign w_en3     = ~r_v3_q | out_ready;
    assign w_en2     = ~r_v2_q | w_en3;
    assign w_en1     = ~r_v1_q | w_en2;
    assign w_in_sign = in_signed & in_data[N-1];

    always_comb begin
        w_v1_d    = r_v1_q;
        w_sign1_d = r_sign1_q;
        w_mag1_d  = r_mag1_q;
        w_v2_d    = r_v2_q;
        w_sign2_d = r_sign2_q;
        w_mag2_d  = r_mag2_q;
        w_cnt2_d  = r_cnt2_q;
        w_zero2_d = r_zero2_q;
        w_v3_d    = r_v3_q;
        w_sign3_d = r_sign3_q;
        w_cnt3_d  = r_cnt3_q;
        w_norm3_d = r_norm3_q;
        w_zero3_d = r_zero3_q;

        if (w_en1) begin
            w_v1_d    = in_valid;
            w_sign1_d = w_in_sign;
            // Negating the most-negative value wraps to 2^(N-1), which is
            // exactly the required unsigned magnitude.
            w_mag1_d  = w_in_sign ? (~in_data + N'(1)) : in_data;
        end

        if (w_en2) begin
            w_v2_d    = r_v1_q;
            w_sign2_d = r_sign1_q;
            w_mag2_d  = r_mag1_q;
            // The tree reports all-ones for a zero input; force the count to 0.
            w_cnt2_d  = w_mag_zero ? '0 : w_tree_cnt;
            w_zero2_d = w_mag_zero;
        end

        if (w_en3) begin
            w_v3_d    = r_v2_q;
            w_sign3_d = r_sign2_q;
            w_cnt3_d  = r_cnt2_q;
            w_norm3_d = r_mag2_q << r_cnt2_q;
            w_zero3_d = r_zero2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1_q    <= 1'b0;
            r_sign1_q <= 1'b0;
            r_mag1_q  <= '0;
            r_v2_q    <= 1'b0;
            r_sign2_q <= 1'b0;
            r_mag2_q  <= '0;
            r_cnt2_q  <= '0;
            r_zero2_q <= 1'b0;
            r_v3_q    <= 1'b0;
            r_sign3_q <= 1'b0;
            r_cnt3_q  <= '0;
            r_norm3_q <= '0;
            r_zero3_q <= 1'b0;
        end else begin
            r_v1_q    <= w_v1_d;
            r_sign1_q <= w_sign1_d;
            r_mag1_q  <= w_mag1_d;
            r_v2_q    <= w_v2_d;
            r_sign2_q <= w_sign2_d;
            r_mag2_q  <= w_mag2_d;
            r_cnt2_q  <= w_cnt2_d;
            r_zero2_q <= w_zero2_d;
            r_v3_q    <= w_v3_d;
            r_sign3_q <= w_sign3_d;
            r_cnt3_q  <= w_cnt3_d;
            r_norm3_q <= w_norm3_d;
            r_zero3_q <= w_zero3_d;
        end
    end

    assign in_ready  = w_en1;
    assign out_valid = r_v3_q;
    assign out_sign  = r_sign3_q;
    assign out_cnt   = r_cnt3_q;
    assign out_norm  = r_norm3_q;
    assign out_zero  = r_zero3_q;

endmodule
`default_nettype wire
